// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer: FSM states, octave-0
// divider table and the layout of an 11-bit note ROM entry.
package note_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        GAP,
        DONE
    } state_e;

    localparam int ENTRY_W  = 11;
    localparam int OCT_LSB  = 8;
    localparam int SEMI_LSB = 4;
    localparam int DUR_LSB  = 0;

    localparam logic [2:0]         OCT_END   = 3'd7;
    localparam logic [3:0]         SEMI_END  = 4'd15;
    localparam logic [3:0]         SEMI_REST = 4'd12;
    localparam logic [ENTRY_W-1:0] END_ENTRY = 11'h7F0;

    // Octave-0 half-period counts, C..B.
    localparam logic [14:0] BASE_DIV [12] = '{
        15'd30581, 15'd28860, 15'd27248, 15'd25707, 15'd24272, 15'd22904,
        15'd21626, 15'd20408, 15'd19260, 15'd18182, 15'd17159, 15'd16197
    };

    function automatic logic [14:0] base_div(input logic [3:0] semi);
        if (semi < SEMI_REST) return BASE_DIV[semi];
        return '0;
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the melody player and its controller:
// the controller is the master, the sequencer the slave.
interface note_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DIV_W  = 15
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic              busy;
    logic              tone_en;
    logic [DIV_W-1:0]  divider;
    logic [ADDR_W-1:0] note_idx;
    logic              done;

    modport master (
        output start, stop, loop_en,
        input  busy, tone_en, divider, note_idx, done
    );

    modport slave (
        input  start, stop, loop_en,
        output busy, tone_en, divider, note_idx, done
    );
endinterface

// File: rtl/note_rom.sv
// Melody ROM: synchronous read, one cycle of latency. Unused addresses
// hold the end marker so a short melody terminates cleanly.
module note_rom
    import note_seq_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                clk_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [ENTRY_W-1:0]  data_o
);

    always_ff @(posedge clk_i) begin
        case (addr_i)
            ADDR_W'(0): data_o <= 11'h101;  // oct 1, C, 2 ticks
            ADDR_W'(1): data_o <= 11'h0C0;  // rest, 1 tick
            ADDR_W'(2): data_o <= 11'h242;  // oct 2, E, 3 ticks
            default:    data_o <= END_ENTRY;
        endcase
    end

endmodule

// File: rtl/note_sequencer.sv
// Steps through the note ROM at a fixed tempo and drives the tone generator's
// divider/enable. Define ARTICULATION_GAP_EN to insert a silent gap after each note.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int TICK_DIV = 25000,
    parameter int ADDR_W   = 5,
    parameter int DIV_W    = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    note_sequencer_if.slave bus
);

    localparam int PS_W = $clog2(TICK_DIV + 1);
`ifdef ARTICULATION_GAP_EN
    localparam int GAP_CYCLES = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] note_idx_q;
    logic [DIV_W-1:0]  divider_q;
    logic              tone_en_q;
    logic              busy_q;
    logic              done_q;
    logic [PS_W-1:0]   ps_q;
    logic [3:0]        dur_q;
    logic              wrap_q;

    logic [ENTRY_W-1:0] rom_data;
    logic [2:0]         oct;
    logic [3:0]         semi;
    logic [3:0]         dur;
    logic               is_end;
    logic               pitched;
    logic               tick;
    logic [14:0]        div_shift;
    logic [DIV_W-1:0]   div_trunc;
    logic [DIV_W-1:0]   div_d;

    note_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk_i  (clk),
        .addr_i (note_idx_q),
        .data_o (rom_data)
    );

    assign oct     = rom_data[OCT_LSB +: 3];
    assign semi    = rom_data[SEMI_LSB +: 4];
    assign dur     = rom_data[DUR_LSB +: 4];
    // Running off the top of the ROM behaves exactly like reading an end marker.
    assign is_end  = ((oct == OCT_END) && (semi == SEMI_END)) || wrap_q;
    assign pitched = semi < SEMI_REST;
    assign tick    = ps_q == PS_W'(TICK_DIV - 1);

    assign div_shift = base_div(semi) >> oct;
    assign div_trunc = DIV_W'(div_shift);
    assign div_d     = (div_trunc == '0) ? DIV_W'(1) : div_trunc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            note_idx_q <= '0;
            divider_q  <= '0;
            tone_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ps_q       <= '0;
            dur_q      <= '0;
            wrap_q     <= 1'b0;
        end else if (bus.stop) begin
            state_q   <= IDLE;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        note_idx_q <= '0;
                        wrap_q     <= 1'b0;
                    end
                end
                FETCH: state_q <= DECODE;
                DECODE: begin
                    wrap_q <= 1'b0;
                    if (is_end) begin
                        if (bus.loop_en) begin
                            note_idx_q <= '0;
                            state_q    <= FETCH;
                        end else begin
                            tone_en_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end else begin
                        // Rests silence the tone but keep the last pitch loaded.
                        tone_en_q <= pitched;
                        if (pitched) divider_q <= div_d;
                        ps_q    <= '0;
                        dur_q   <= dur;
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        ps_q <= '0;
                        if (dur_q == 4'd0) begin
                            note_idx_q <= note_idx_q + ADDR_W'(1);
                            wrap_q     <= &note_idx_q;
`ifdef ARTICULATION_GAP_EN
                            tone_en_q  <= 1'b0;
                            state_q    <= GAP;
`else
                            state_q    <= FETCH;
`endif
                        end else begin
                            dur_q <= dur_q - 4'd1;
                        end
                    end else begin
                        ps_q <= ps_q + PS_W'(1);
                    end
                end
`ifdef ARTICULATION_GAP_EN
                GAP: begin
                    if (ps_q == PS_W'(GAP_CYCLES - 1)) begin
                        ps_q    <= '0;
                        state_q <= FETCH;
                    end else begin
                        ps_q <= ps_q + PS_W'(1);
                    end
                end
`endif
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    tone_en_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.tone_en  = tone_en_q;
    assign bus.divider  = divider_q;
    assign bus.note_idx = note_idx_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer (TICK_DIV=4): directed run-length vector table plus
// random start/stop traffic checked against a melody-timeline reference model.
module tb_note_sequencer;

    localparam int TICK = 4;
`ifdef ARTICULATION_GAP_EN
    localparam int GAPC = 1;
`else
    localparam int GAPC = 0;
`endif

    typedef struct {
        bit          busy;
        bit          ten;
        logic [14:0] div;
        logic [4:0]  idx;
        bit          done;
    } out_t;

    typedef struct {
        bit s, p, l;
        int n;
        bit busy, ten;
        int div, idx;
        bit done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(5), .DIV_W(15)) bus ();

    note_sequencer #(.TICK_DIV(TICK), .ADDR_W(5), .DIV_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] song [32];
    int          base [12] = '{30581, 28860, 27248, 25707, 24272, 22904,
                               21626, 20408, 19260, 18182, 17159, 16197};
    out_t exp_q [$];
    out_t cur;
    vec_t vt [$];

    task automatic compare(input string tag, input out_t e);
        n_checks++;
        if (bus.busy !== e.busy || bus.tone_en !== e.ten || bus.divider !== e.div ||
            bus.note_idx !== e.idx || bus.done !== e.done) begin
            n_fail++;
            $display("FAIL %s t=%0t got busy=%0b ten=%0b div=%0d idx=%0d done=%0b want busy=%0b ten=%0b div=%0d idx=%0d done=%0b",
                     tag, $time, bus.busy, bus.tone_en, bus.divider, bus.note_idx, bus.done,
                     e.busy, e.ten, e.div, e.idx, e.done);
        end
    endtask

    function automatic out_t mk(bit b, bit t, logic [14:0] d, logic [4:0] i, bit dn);
        out_t o;
        o.busy = b; o.ten = t; o.div = d; o.idx = i; o.done = dn;
        return o;
    endfunction

    // Expected per-cycle trace of one playback, derived from the melody list.
    task automatic build(input logic [14:0] div0, input bit loop);
        bit          ten = 1'b0;
        logic [14:0] div = div0;
        logic [4:0]  idx = '0;
        bit          wrap = 1'b0;
        int          d;
        logic [10:0] e;
        while (exp_q.size() < 2000) begin
            repeat (2) exp_q.push_back(mk(1, ten, div, idx, 0));
            e = song[idx];
            if (e[10:4] == 7'h7F || wrap) begin
                wrap = 1'b0;
                if (loop) begin
                    idx = '0;
                    continue;
                end
                exp_q.push_back(mk(1, 0, div, idx, 1));
                exp_q.push_back(mk(0, 0, div, idx, 0));
                break;
            end
            if (e[7:4] < 12) begin
                d = base[e[7:4]] >> e[10:8];
                div = (d == 0) ? 15'd1 : d[14:0];
                ten = 1'b1;
            end else begin
                ten = 1'b0;
            end
            repeat ((e[3:0] + 1) * TICK) exp_q.push_back(mk(1, ten, div, idx, 0));
            wrap = (idx == 5'd31);
            idx = idx + 5'd1;
            if (GAPC > 0) begin
                ten = 1'b0;
                repeat (GAPC) exp_q.push_back(mk(1, ten, div, idx, 0));
            end
        end
    endtask

    task automatic model_step(input bit s, input bit p, input bit l);
        if (p) begin
            exp_q.delete();
            cur.busy = 0; cur.ten = 0; cur.done = 0;
        end else if (s && !cur.busy) begin
            build(cur.div, l);
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur.done = 0;
        end
    endtask

    task automatic drive(input bit s, input bit p, input bit l);
        bus.start = s; bus.stop = p; bus.loop_en = l;
    endtask

    task automatic add(bit s, bit p, bit l, int n, bit b, bit t, int d, int i, bit dn);
        vec_t v;
        v.s = s; v.p = p; v.l = l; v.n = n;
        v.busy = b; v.ten = t; v.div = d; v.idx = i; v.done = dn;
        vt.push_back(v);
    endtask

    initial begin
        bit run_loop;
        bit s, p;
        int ones;
        foreach (song[i]) song[i] = 11'h7F0;
        song[0] = 11'h101;
        song[1] = 11'h0C0;
        song[2] = 11'h242;

        drive(0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifndef ARTICULATION_GAP_EN
        // single pass: note, rest (start ignored mid-rest), note, end -> done
        add(1,0,0, 1,  0,0,0,0,0);
        add(0,0,0, 2,  1,0,0,0,0);
        add(0,0,0, 8,  1,1,15290,0,0);
        add(0,0,0, 2,  1,1,15290,1,0);
        add(1,0,0, 1,  1,0,15290,1,0);
        add(0,0,0, 3,  1,0,15290,1,0);
        add(0,0,0, 2,  1,0,15290,2,0);
        add(0,0,0, 12, 1,1,6068,2,0);
        add(0,0,0, 2,  1,1,6068,3,0);
        add(0,0,0, 1,  1,0,6068,3,1);
        add(0,0,0, 2,  0,0,6068,3,0);
        // start together with stop in IDLE
        add(1,1,0, 1,  0,0,6068,3,0);
        add(0,0,0, 2,  0,0,6068,3,0);
        // stop two cycles into PLAY
        add(1,0,0, 1,  0,0,6068,3,0);
        add(0,0,0, 2,  1,0,6068,0,0);
        add(0,0,0, 2,  1,1,15290,0,0);
        add(0,1,0, 1,  1,1,15290,0,0);
        add(0,0,0, 4,  0,0,15290,0,0);
        // loop at end marker, replay first note, then stop
        add(1,0,1, 1,  0,0,15290,0,0);
        add(0,0,1, 2,  1,0,15290,0,0);
        add(0,0,1, 8,  1,1,15290,0,0);
        add(0,0,1, 2,  1,1,15290,1,0);
        add(0,0,1, 4,  1,0,15290,1,0);
        add(0,0,1, 2,  1,0,15290,2,0);
        add(0,0,1, 12, 1,1,6068,2,0);
        add(0,0,1, 2,  1,1,6068,3,0);
        add(0,0,1, 2,  1,1,6068,0,0);
        add(0,0,1, 7,  1,1,15290,0,0);
        add(0,1,1, 1,  1,1,15290,0,0);
        add(0,0,0, 2,  0,0,15290,0,0);
        foreach (vt[r]) begin
            for (int c = 0; c < vt[r].n; c++) begin
                compare($sformatf("vec%0d.%0d", r, c),
                        mk(vt[r].busy, vt[r].ten, vt[r].div[14:0], vt[r].idx[4:0], vt[r].done));
                drive(vt[r].s, vt[r].p, vt[r].l);
                @(negedge clk);
            end
        end
`else
        // gap build: 8 tone cycles, then 1 gap + 2 fetch/decode cycles silent
        drive(1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0);
        repeat (2) @(negedge clk);
        ones = 0;
        repeat (8) begin
            ones += int'(bus.tone_en);
            @(negedge clk);
        end
        n_checks++;
        if (ones != 8) begin
            n_fail++;
            $display("FAIL gap_note got ten_cycles=%0d want 8", ones);
        end
        for (int g = 0; g < 3; g++) begin
            compare($sformatf("gap%0d", g), mk(1, 0, 15'd15290, 5'd1, 0));
            @(negedge clk);
        end
        drive(0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0);
        @(negedge clk);
`endif

        // asynchronous reset in the middle of a note
        drive(1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.tone_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst got ten=%0b want 1", bus.tone_en);
        end
        #2 rst_n = 1'b0;
        #1 compare("rst_mid", mk(0, 0, 15'd0, 5'd0, 0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // random start/stop traffic against the timeline model
        cur = mk(0, 0, 15'd0, 5'd0, 0);
        exp_q.delete();
        run_loop = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            compare($sformatf("rnd%0d", k), cur);
            if (!cur.busy) run_loop = $urandom_range(1, 0) == 1;
            s = $urandom_range(7, 0) == 0;
            p = $urandom_range(49, 0) == 0;
            if (cur.busy && run_loop && exp_q.size() < 8) p = 1'b1;
            drive(s, p, run_loop);
            model_step(s, p, run_loop);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
